// File: rtl/addsub_response_checker.sv
// addsub_response_checker: checks adder/subtractor responses against a golden model over an exhaustive sweep
module addsub_response_checker #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 512,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               subtract,
  input  logic [WIDTH-1:0]   Result,
  input  logic               Cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               mismatch,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [2*WIDTH:0]   fail_vec,
  output logic               fail_valid
);
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  state_t r_state, w_next;
  logic               r_s1_valid;
  logic [2*WIDTH:0]   r_s1_vec;
  logic [WIDTH:0]     r_s1_gold, r_s1_obs;
  logic [WIDTH:0]     w_gold;
  logic               w_chk, w_bad, w_last;
  assign w_gold = subtract ? {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1) : {1'b0, A} + {1'b0, B};
  assign w_chk  = r_state == CHECK && r_s1_valid && !start;
  assign w_bad  = r_s1_gold != r_s1_obs;
  assign w_last = w_chk && vec_count == CNT_W'(NUM_VECTORS - 1);
  assign busy   = r_state == CHECK;
  assign done   = r_state == DONE;
  assign pass   = done && err_count == '0;
  always_comb begin
    w_next = start ? CHECK : w_last ? DONE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // the final counted vector closes stage 1 so nothing is left in flight at DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_vec   <= '0;
      r_s1_gold  <= '0;
      r_s1_obs   <= '0;
    end else begin
      r_s1_valid <= r_state == CHECK && in_valid && !start && !w_last;
      if (in_valid) begin
        r_s1_vec  <= {subtract, A, B};
        r_s1_gold <= w_gold;
        r_s1_obs  <= {Cout, Result};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch   <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (start) begin
      mismatch   <= 1'b0;
      vec_count  <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      mismatch <= w_chk && w_bad;
      if (w_chk) begin
        vec_count <= vec_count + CNT_W'(vec_count != '1);
        if (w_bad) begin
          err_count <= err_count + CNT_W'(err_count != '1);
          if (!fail_valid) begin
            fail_vec   <= r_s1_vec;
            fail_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule
